// File: rtl/qpsk_symbol_demod.sv
// QPSK symbol demodulator: correlates 16-sample symbols against cos/sin
// references, accumulates I/Q over one symbol and decides the 2-bit symbol.
// Mapping: bit1 = sign of I correlation, bit0 = sign of Q correlation.
module qpsk_symbol_demod #(
  parameter int DATA_W = 10,
  parameter int ACC_W  = 22,
  parameter int THRESH = 20000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     frame_start,
  output logic [1:0]               bits_out,
  output logic                     bits_valid,
  output logic signed [ACC_W-1:0]  i_corr,
  output logic signed [ACC_W-1:0]  q_corr,
  output logic                     low_conf
);

  localparam int COEF_W = 8;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] THR = ACC_W'(THRESH);

  // Cosine reference, amplitude 64, one full period over 16 samples.
  function automatic logic signed [COEF_W-1:0] cos_ref(input logic [3:0] k);
    case (k)
      4'd0:    cos_ref = 8'sd64;
      4'd1:    cos_ref = 8'sd59;
      4'd2:    cos_ref = 8'sd45;
      4'd3:    cos_ref = 8'sd24;
      4'd4:    cos_ref = 8'sd0;
      4'd5:    cos_ref = -8'sd24;
      4'd6:    cos_ref = -8'sd45;
      4'd7:    cos_ref = -8'sd59;
      4'd8:    cos_ref = -8'sd64;
      4'd9:    cos_ref = -8'sd59;
      4'd10:   cos_ref = -8'sd45;
      4'd11:   cos_ref = -8'sd24;
      4'd12:   cos_ref = 8'sd0;
      4'd13:   cos_ref = 8'sd24;
      4'd14:   cos_ref = 8'sd45;
      default: cos_ref = 8'sd59;
    endcase
  endfunction

  // Sine is the cosine delayed by a quarter period (4 samples, modulo 16).
  function automatic logic signed [COEF_W-1:0] sin_ref(input logic [3:0] k);
    logic [3:0] ks;
    ks      = k - 4'd4;
    sin_ref = cos_ref(ks);
  endfunction

  // Sign-extend a full-precision product to accumulator width.
  function automatic logic signed [ACC_W-1:0] widen(input logic signed [PROD_W-1:0] p);
    widen = {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Strictly positive test; a sum of exactly zero decides bit 0.
  function automatic logic positive(input logic signed [ACC_W-1:0] v);
    positive = !v[ACC_W-1] && (v != '0);
  endfunction

  // Magnitude below the confidence threshold.
  function automatic logic below_thresh(input logic signed [ACC_W-1:0] v);
    below_thresh = (v < THR) && (v > -THR);
  endfunction

  logic [3:0]               idx_p0;
  logic signed [ACC_W-1:0]  acc_i_p0;
  logic signed [ACC_W-1:0]  acc_q_p0;

  logic [3:0]               idx_use;
  logic signed [COEF_W-1:0] cref;
  logic signed [COEF_W-1:0] sref;
  logic signed [PROD_W-1:0] samp_ext;
  logic signed [PROD_W-1:0] cos_ext;
  logic signed [PROD_W-1:0] sin_ext;
  logic signed [PROD_W-1:0] prod_i;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  base_i;
  logic signed [ACC_W-1:0]  base_q;
  logic signed [ACC_W-1:0]  sum_i;
  logic signed [ACC_W-1:0]  sum_q;
  logic                     last;

  logic [1:0]               bits_p1;
  logic                     vld_p1;
  logic signed [ACC_W-1:0]  i_corr_p1;
  logic signed [ACC_W-1:0]  q_corr_p1;
  logic                     low_conf_p1;

  // Stage 0: reference lookup, products and running sums for the current sample.
  // A frame_start sample is treated as index 0 and replaces the partial sums.
  always_comb begin
    idx_use  = frame_start ? 4'd0 : idx_p0;
    cref     = cos_ref(idx_use);
    sref     = sin_ref(idx_use);
    samp_ext = {{COEF_W{sample_in[DATA_W-1]}}, sample_in};
    cos_ext  = {{DATA_W{cref[COEF_W-1]}}, cref};
    sin_ext  = {{DATA_W{sref[COEF_W-1]}}, sref};
    prod_i   = samp_ext * cos_ext;
    prod_q   = samp_ext * sin_ext;
    base_i   = frame_start ? '0 : acc_i_p0;
    base_q   = frame_start ? '0 : acc_q_p0;
    sum_i    = base_i + widen(prod_i);
    sum_q    = base_q + widen(prod_q);
    last     = sample_valid && !frame_start && (idx_p0 == 4'hF);
  end

  // Stage 1: accumulate, and on the 16th sample publish the decision and restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_p0      <= 4'd0;
      acc_i_p0    <= '0;
      acc_q_p0    <= '0;
      vld_p1      <= 1'b0;
      bits_p1     <= 2'b00;
      i_corr_p1   <= '0;
      q_corr_p1   <= '0;
      low_conf_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (sample_valid) begin
        idx_p0 <= idx_use + 4'd1;
        if (last) begin
          acc_i_p0    <= '0;
          acc_q_p0    <= '0;
          vld_p1      <= 1'b1;
          bits_p1     <= {positive(sum_i), positive(sum_q)};
          i_corr_p1   <= sum_i;
          q_corr_p1   <= sum_q;
          low_conf_p1 <= below_thresh(sum_i) || below_thresh(sum_q);
        end else begin
          acc_i_p0 <= sum_i;
          acc_q_p0 <= sum_q;
        end
      end
    end
  end

  assign bits_out   = bits_p1;
  assign bits_valid = vld_p1;
  assign i_corr     = i_corr_p1;
  assign q_corr     = q_corr_p1;
  assign low_conf   = low_conf_p1;

endmodule

// File: doc/qpsk_symbol_demod.md
Name: qpsk_symbol_demod

Overview:
- Downstream consumer of the 16-sample QPSK symbol waveform generators.
- Correlates each 16-sample symbol against internal cos/sin references and accumulates I and Q over one symbol period.
- Decides the transmitted 2-bit symbol and pulses it out with the raw correlation sums.
- Mapping, shared with the generators: sample[k] = A*(sI*cos(2*pi*k/16) + sQ*sin(2*pi*k/16)); bit1 selects sI and bit0 selects sQ (0 -> -1, 1 -> +1). Symbol 00 = -cos-sin.

Parameters:
- DATA_W, 10, signed input sample width.
- ACC_W, 22, signed accumulator and correlation output width. Must be >= DATA_W+12.
- THRESH, 20000, minimum |I| and |Q| magnitude for a confident decision.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sample_in  input  DATA_W  signed received sample.
- sample_valid  input  1  sample_in is valid this cycle.
- frame_start  input  1  qualified by sample_valid; marks the current sample as index 0 of a new symbol.
- bits_out  output  2  decided symbol {bit1=I, bit0=Q}.
- bits_valid  output  1  one-cycle pulse when bits_out, i_corr and q_corr are updated.
- i_corr  output  ACC_W  signed final I correlation of the last symbol.
- q_corr  output  ACC_W  signed final Q correlation of the last symbol.
- low_conf  output  1  valid with bits_valid: |i_corr| < THRESH or |q_corr| < THRESH.

Behaviour:
- Reset (async assert, sync deassert is the integrator's responsibility): all outputs 0, index counter 0, accumulators 0.
- Reference ROMs, 8-bit signed, indexed by the 4-bit sample index k.
  - COS[k] for k=0..15 = 64, 59, 45, 24, 0, -24, -45, -59, -64, -59, -45, -24, 0, 24, 45, 59.
  - SIN[k] = COS[(k-4) mod 16].
- Per accepted sample (sample_valid=1): acc_i += sample_in*COS[idx]; acc_q += sample_in*SIN[idx].
  - Each product is a full-precision signed (DATA_W+8)-bit value, sign-extended to ACC_W.
  - No saturation. Overflow is impossible at defaults.
- Index counter idx, 4 bits:
  - Increments by 1 per accepted sample and wraps 15 -> 0.
  - sample_valid=0: idx, accumulators and outputs hold; bits_valid=0.
- frame_start=1 with sample_valid=1:
  - The sample is processed as idx 0: the accumulators are loaded with its products, not added.
  - The partial symbol is discarded and no bits_valid pulse is produced, even if the old idx was 15.
  - idx becomes 1.
- frame_start with sample_valid=0 is ignored.
- Symbol completion (accepted sample at idx 15, no frame_start):
  - On that rising edge, i_corr/q_corr <= final sums (including the idx-15 products).
  - bits_out <= {i_final > 0, q_final > 0}; a sum of exactly 0 decides bit 0.
  - low_conf is computed from the final sums.
  - bits_valid <= 1 for exactly one cycle.
  - Accumulators are cleared, so the next accepted sample starts a fresh symbol.
  - Latency: outputs are visible the cycle after the 16th sample is presented.
- Back-to-back symbols with continuous sample_valid produce a bits_valid pulse every 16 cycles with no gap or stall.
- Reset asserted mid-symbol: immediate clear. After release, the first accepted sample is idx 0.
- i_corr, q_corr, bits_out and low_conf hold their values between pulses.

Test Plan:
- Reset, then 16 valid samples of symbol 00 (-100,-131,-141,-131,-100,-54,0,54,100,131,141,131,100,54,0,-54) with frame_start on the first sample -> single bits_valid pulse 1 cycle after the 16th sample; i_corr=-51016, q_corr=-51016, bits_out=00, low_conf=0.
- Same samples negated (symbol 11) -> i_corr=q_corr=+51016, bits_out=11.
- Symbols 00, 11, 00 streamed on 48 consecutive valid cycles -> pulses exactly 16 cycles apart, bits 00, 11, 00; accumulators show no carry-over.
- Symbol 00 with sample_valid deasserted for 3 random cycles between samples -> identical result (-51016/-51016, 00); the pulse is delayed by the stall count.
- 9 samples, then frame_start with a fresh 16-sample symbol 11 -> no pulse for the partial; one pulse with +51016/+51016, bits 11.
- All-zero samples for 16 cycles -> i_corr=q_corr=0, bits_out=00, low_conf=1.
- rst_n pulsed low after sample 7 -> outputs 0 at once; a following complete symbol 00 decodes correctly without frame_start.
